// File: rtl/maxpool_layer_if.sv
// Channel bundle around the 2x2 max-pool stage: eight ReLU samples in,
// eight pooled samples plus pooled coordinates and end-of-frame out.
interface maxpool_layer_if #(
  parameter int IN_X       = 24,
  parameter int IN_Y       = 24,
  parameter int DATA_WIDTH = 69,
  parameter int OX_W       = $clog2(IN_X/2),
  parameter int OY_W       = $clog2(IN_Y/2)
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] relu_result_1, relu_result_2, relu_result_3, relu_result_4;
  logic signed [DATA_WIDTH-1:0] relu_result_5, relu_result_6, relu_result_7, relu_result_8;
  logic signed [DATA_WIDTH-1:0] pool_result_1, pool_result_2, pool_result_3, pool_result_4;
  logic signed [DATA_WIDTH-1:0] pool_result_5, pool_result_6, pool_result_7, pool_result_8;
  logic                         out_valid;
  logic [OY_W-1:0]              out_row;
  logic [OX_W-1:0]              out_col;
  logic                         frame_done;

  modport master (
    output in_valid,
    output relu_result_1, relu_result_2, relu_result_3, relu_result_4,
    output relu_result_5, relu_result_6, relu_result_7, relu_result_8,
    input  pool_result_1, pool_result_2, pool_result_3, pool_result_4,
    input  pool_result_5, pool_result_6, pool_result_7, pool_result_8,
    input  out_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid,
    input  relu_result_1, relu_result_2, relu_result_3, relu_result_4,
    input  relu_result_5, relu_result_6, relu_result_7, relu_result_8,
    output pool_result_1, pool_result_2, pool_result_3, pool_result_4,
    output pool_result_5, pool_result_6, pool_result_7, pool_result_8,
    output out_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/maxpool_layer.sv
// 2x2 stride-2 max-pooling over a raster-scan IN_X x IN_Y map, 8 channels in lockstep.
// Horizontal pairs are reduced on the fly; even-row results wait in a half-width line buffer.
module maxpool_layer #(
  parameter int IN_X       = 24,
  parameter int IN_Y       = 24,
  parameter int DATA_WIDTH = 69,
  parameter int OX_W       = $clog2(IN_X/2),
  parameter int OY_W       = $clog2(IN_Y/2)
) (
  input logic           clk,
  input logic           rst,
  maxpool_layer_if.slave bus
);
  localparam int NCH   = 8;
  localparam int COL_W = OX_W + 1;
  localparam int ROW_W = OY_W + 1;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  sample_t          w_relu    [NCH];
  sample_t          w_hMax    [NCH];
  sample_t          w_poolMax [NCH];
  sample_t          r_hHold   [NCH];
  sample_t          r_pool    [NCH];
  sample_t          r_lineBuf [NCH][IN_X/2];
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_outValid;
  logic             r_frameDone;
  logic [OY_W-1:0]  r_outRow;
  logic [OX_W-1:0]  r_outCol;
  logic [OX_W-1:0]  w_pairIdx;
  logic             w_colLast;
  logic             w_rowLast;

  assign w_relu[0] = bus.relu_result_1;
  assign w_relu[1] = bus.relu_result_2;
  assign w_relu[2] = bus.relu_result_3;
  assign w_relu[3] = bus.relu_result_4;
  assign w_relu[4] = bus.relu_result_5;
  assign w_relu[5] = bus.relu_result_6;
  assign w_relu[6] = bus.relu_result_7;
  assign w_relu[7] = bus.relu_result_8;

  assign w_pairIdx = r_col[COL_W-1:1];
  assign w_colLast = (r_col == COL_W'(IN_X-1));
  assign w_rowLast = (r_row == ROW_W'(IN_Y-1));

  // Both reductions are signed so negative samples pool correctly.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_hMax[c]    = (r_hHold[c] > w_relu[c]) ? r_hHold[c] : w_relu[c];
      w_poolMax[c] = (r_lineBuf[c][w_pairIdx] > w_hMax[c]) ? r_lineBuf[c][w_pairIdx] : w_hMax[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_outValid  <= 1'b0;
      r_frameDone <= 1'b0;
      r_outRow    <= '0;
      r_outCol    <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_hHold[c] <= '0;
        r_pool[c]  <= '0;
      end
    end else begin
      r_outValid  <= 1'b0;
      r_frameDone <= 1'b0;
      if (bus.in_valid) begin
        if (w_colLast) begin
          r_col <= '0;
          r_row <= w_rowLast ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
          if (!r_col[0]) r_hHold[c] <= w_relu[c];
        end
        // Bottom-right pixel of a window closes it.
        if (r_col[0] && r_row[0]) begin
          for (int c = 0; c < NCH; c++) r_pool[c] <= w_poolMax[c];
          r_outRow    <= r_row[ROW_W-1:1];
          r_outCol    <= w_pairIdx;
          r_outValid  <= 1'b1;
          r_frameDone <= w_colLast && w_rowLast;
        end
      end
    end
  end

  // Not reset: every even row rewrites each entry before the odd row reads it.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid && r_col[0] && !r_row[0]) begin
      for (int c = 0; c < NCH; c++) r_lineBuf[c][w_pairIdx] <= w_hMax[c];
    end
  end

  assign bus.pool_result_1 = r_pool[0];
  assign bus.pool_result_2 = r_pool[1];
  assign bus.pool_result_3 = r_pool[2];
  assign bus.pool_result_4 = r_pool[3];
  assign bus.pool_result_5 = r_pool[4];
  assign bus.pool_result_6 = r_pool[5];
  assign bus.pool_result_7 = r_pool[6];
  assign bus.pool_result_8 = r_pool[7];
  assign bus.out_valid     = r_outValid;
  assign bus.out_row       = r_outRow;
  assign bus.out_col       = r_outCol;
  assign bus.frame_done    = r_frameDone;
endmodule

// File: tb/tb_maxpool_layer.sv
// Scenario bench for maxpool_layer: a frame model computes each window's max
// when its bottom-right pixel is driven, and a negedge monitor pops and compares.
module tb_maxpool_layer;
  localparam int IN_X = 24;
  localparam int IN_Y = 24;
  localparam int DW   = 69;
  localparam int NCH  = 8;

  typedef struct packed {
    logic [NCH-1:0][DW-1:0] v;
    logic [3:0]             row;
    logic [3:0]             col;
    logic                   fd;
    int                     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   validCount = 0;
  int   frameDoneCount = 0;
  int   consecCount = 0;
  logic prevValid = 1'b0;
  int   tbRow = 0;
  int   tbCol = 0;
  exp_t sbQ [$];

  logic signed [DW-1:0] frameMem [NCH][IN_Y][IN_X];
  logic signed [DW-1:0] stim     [NCH];
  logic signed [DW-1:0] obs      [NCH];

  maxpool_layer_if #(.IN_X(IN_X), .IN_Y(IN_Y), .DATA_WIDTH(DW)) bus ();

  maxpool_layer #(.IN_X(IN_X), .IN_Y(IN_Y), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs[0] = bus.pool_result_1;
  assign obs[1] = bus.pool_result_2;
  assign obs[2] = bus.pool_result_3;
  assign obs[3] = bus.pool_result_4;
  assign obs[4] = bus.pool_result_5;
  assign obs[5] = bus.pool_result_6;
  assign obs[6] = bus.pool_result_7;
  assign obs[7] = bus.pool_result_8;

  function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                                input logic signed [DW-1:0] c, input logic signed [DW-1:0] d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Scoreboard consumer: every out_valid pulse must match the oldest expected window.
  always @(negedge clk) begin
    exp_t e;
    int   badCh;
    if (bus.out_valid === 1'b1) begin
      validCount++;
      if (prevValid) consecCount++;
      if (bus.frame_done === 1'b1) frameDoneCount++;
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: out_valid=1 at cycle %0d row=%0d col=%0d, required no output", cyc, bus.out_row, bus.out_col);
      end else begin
        e = sbQ.pop_front();
        badCh = -1;
        for (int ch = 0; ch < NCH; ch++) if (badCh < 0 && obs[ch] !== e.v[ch]) badCh = ch;
        if (badCh >= 0) begin
          errors++;
          $display("[TB] FAIL pool_value: ch%0d got %0d, expected %0d (window %0d,%0d)", badCh + 1, obs[badCh], $signed(e.v[badCh]), e.row, e.col);
        end
        checks++;
        if (bus.out_row !== e.row || bus.out_col !== e.col) begin
          errors++;
          $display("[TB] FAIL coords: got (%0d,%0d), expected (%0d,%0d)", bus.out_row, bus.out_col, e.row, e.col);
        end
        checks++;
        if (bus.frame_done !== e.fd) begin
          errors++;
          $display("[TB] FAIL frame_done: got %0b, expected %0b at (%0d,%0d)", bus.frame_done, e.fd, e.row, e.col);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL latency: output at cycle %0d, expected cycle %0d", cyc, e.cyc);
        end
      end
    end else begin
      checks++;
      if (bus.frame_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL frame_done_idle: got %b while out_valid=0, expected 0", bus.frame_done);
      end
    end
    prevValid = (bus.out_valid === 1'b1);
  end

  task automatic set_inputs(input logic v);
    bus.in_valid      = v;
    bus.relu_result_1 = stim[0];
    bus.relu_result_2 = stim[1];
    bus.relu_result_3 = stim[2];
    bus.relu_result_4 = stim[3];
    bus.relu_result_5 = stim[4];
    bus.relu_result_6 = stim[5];
    bus.relu_result_7 = stim[6];
    bus.relu_result_8 = stim[7];
  endtask

  task automatic zero_stim();
    for (int ch = 0; ch < NCH; ch++) stim[ch] = '0;
  endtask

  // One valid beat; pushes the window max when this pixel closes a window.
  task automatic drive_beat();
    exp_t e;
    @(negedge clk);
    set_inputs(1'b1);
    for (int ch = 0; ch < NCH; ch++) frameMem[ch][tbRow][tbCol] = stim[ch];
    if ((tbRow % 2 == 1) && (tbCol % 2 == 1)) begin
      for (int ch = 0; ch < NCH; ch++)
        e.v[ch] = max4(frameMem[ch][tbRow-1][tbCol-1], frameMem[ch][tbRow-1][tbCol],
                       frameMem[ch][tbRow][tbCol-1], frameMem[ch][tbRow][tbCol]);
      e.row = 4'(tbRow / 2);
      e.col = 4'(tbCol / 2);
      e.fd  = (tbRow == IN_Y - 1) && (tbCol == IN_X - 1);
      e.cyc = cyc + 1;
      sbQ.push_back(e);
    end
    tbCol++;
    if (tbCol == IN_X) begin
      tbCol = 0;
      tbRow++;
      if (tbRow == IN_Y) tbRow = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_ramp(input int offset, input bit gaps, input int nBeats);
    for (int i = 0; i < nBeats; i++) begin
      for (int ch = 0; ch < NCH; ch++) stim[ch] = DW'(tbRow * IN_X + tbCol + offset);
      drive_beat();
      if (gaps) idle(1 + int'($urandom_range(0, 5)));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tbRow = 0;
    tbCol = 0;
    sbQ.delete();
  endtask

  // Idle long enough for every pushed window to come out, then demand an empty scoreboard.
  task automatic drain(input string name);
    idle(4);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d outputs still pending, expected 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic test_reset();
    for (int ch = 0; ch < NCH; ch++) stim[ch] = DW'(77 + ch);
    rst = 1'b1;
    set_inputs(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: out_valid=%b frame_done=%b, expected 0 0", bus.out_valid, bus.frame_done);
    end
    checks++;
    if (bus.out_row !== '0 || bus.out_col !== '0) begin
      errors++;
      $display("[TB] FAIL reset_coords: got (%0d,%0d), expected (0,0)", bus.out_row, bus.out_col);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs[ch] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_pool: ch%0d got %0d, expected 0", ch + 1, obs[ch]);
      end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tbRow = 0;
    tbCol = 0;
  endtask

  task automatic test_ramp();
    int v0, f0;
    $display("[TB] ramp frame");
    do_reset();
    v0 = validCount;
    f0 = frameDoneCount;
    send_ramp(0, 1'b0, IN_X * IN_Y);
    drain("ramp");
    checks++;
    if (validCount - v0 != 144) begin
      errors++;
      $display("[TB] FAIL ramp_count: got %0d pulses, expected 144", validCount - v0);
    end
    checks++;
    if (frameDoneCount - f0 != 1) begin
      errors++;
      $display("[TB] FAIL ramp_frame_done: got %0d pulses, expected 1", frameDoneCount - f0);
    end
  endtask

  task automatic test_max_position();
    int tbl [4][4] = '{'{9, 1, 2, 3}, '{1, 9, 2, 3}, '{1, 2, 9, 3}, '{1, 2, 3, 9}};
    logic signed [DW-1:0] nine;
    nine = DW'(9);
    $display("[TB] max position");
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < IN_X; c++) begin
        zero_stim();
        if (c < 2) for (int k = 0; k < 4; k++) stim[k] = DW'(tbl[k][r * 2 + c]);
        drive_beat();
        if (r == 1 && c == 1) begin
          idle(1);
          for (int k = 0; k < NCH; k++) begin
            checks++;
            if (obs[k] !== ((k < 4) ? nine : '0)) begin
              errors++;
              $display("[TB] FAIL max_position: ch%0d got %0d, expected %0d", k + 1, obs[k], (k < 4) ? 9 : 0);
            end
          end
        end
      end
    end
    drain("max_position");
  endtask

  task automatic test_signed();
    int win [4] = '{-5, -1, -7, -3};
    logic signed [DW-1:0] minusOne;
    minusOne = '1;
    $display("[TB] signed window");
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < IN_X; c++) begin
        zero_stim();
        if (c < 2) stim[2] = DW'(win[r * 2 + c]);
        drive_beat();
        if (r == 1 && c == 1) begin
          idle(1);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.pool_result_3 !== minusOne) begin
            errors++;
            $display("[TB] FAIL signed_max: valid=%b ch3=%h, expected valid=1 ch3=%h", bus.out_valid, bus.pool_result_3, minusOne);
          end
        end
      end
    end
    drain("signed");
  endtask

  task automatic test_bubbles();
    int v0, f0, c0;
    $display("[TB] bubbles");
    do_reset();
    v0 = validCount;
    f0 = frameDoneCount;
    c0 = consecCount;
    send_ramp(0, 1'b1, IN_X * IN_Y);
    drain("bubbles");
    checks++;
    if (validCount - v0 != 144) begin
      errors++;
      $display("[TB] FAIL bubbles_count: got %0d pulses, expected 144", validCount - v0);
    end
    checks++;
    if (consecCount - c0 != 0) begin
      errors++;
      $display("[TB] FAIL bubbles_consecutive: got %0d back-to-back pulses, expected 0", consecCount - c0);
    end
    checks++;
    if (frameDoneCount - f0 != 1) begin
      errors++;
      $display("[TB] FAIL bubbles_frame_done: got %0d pulses, expected 1", frameDoneCount - f0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    $display("[TB] reset mid-frame");
    do_reset();
    send_ramp(0, 1'b0, 100);
    @(negedge clk);
    rst = 1'b1;
    for (int ch = 0; ch < NCH; ch++) stim[ch] = DW'(4242);
    set_inputs(1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.out_row !== '0 || bus.out_col !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_state: valid=%b fd=%b row=%0d col=%0d, expected all 0", bus.out_valid, bus.frame_done, bus.out_row, bus.out_col);
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_pending: %0d outputs pending before reset, expected 0", sbQ.size());
    end
    sbQ.delete();
    tbRow = 0;
    tbCol = 0;
    v0 = validCount;
    send_ramp(0, 1'b0, IN_X * IN_Y);
    drain("midreset");
    checks++;
    if (validCount - v0 != 144) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d pulses, expected 144", validCount - v0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    $display("[TB] back-to-back frames");
    do_reset();
    v0 = validCount;
    f0 = frameDoneCount;
    send_ramp(0, 1'b0, IN_X * IN_Y);
    send_ramp(1000, 1'b0, IN_X * IN_Y);
    drain("back_to_back");
    checks++;
    if (frameDoneCount - f0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_frame_done: got %0d pulses, expected 2", frameDoneCount - f0);
    end
    checks++;
    if (validCount - v0 != 288) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d pulses, expected 288", validCount - v0);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    zero_stim();
    set_inputs(1'b0);
    test_reset();
    test_ramp();
    test_max_position();
    test_signed();
    test_bubbles();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end
endmodule
